// File: rtl/countdown_timer_bcd_pkg.sv
// countdown_timer_bcd_pkg
//   Shared definitions for the BCD countdown timer: FSM state encoding and
//   the BCD digit limits used by the digit chain.
package countdown_timer_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

endpackage

// File: rtl/countdown_timer_bcd_digit.sv
// bcd_down_digit
//   One BCD digit of the countdown chain. Decrements when dec and borrow_in
//   are both high, wrapping 0 -> WRAP_VAL. A load overrides the decrement.
// Ports
//   clk        in   clock, rising edge
//   clr        in   asynchronous active-low reset (digit -> 0)
//   dec        in   one-second tick, common to the whole chain
//   borrow_in  in   all lower digits are zero (or 1 for the lowest digit)
//   load       in   replace digit with load_val
//   load_val   in   value to load
//   digit      out  current digit
//   borrow_out out  digit==0 & borrow_in
module bcd_down_digit
  import countdown_timer_bcd_pkg::*;
#(
  parameter logic [3:0] WRAP_VAL = BCD_MAX
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       dec,
  input  logic       borrow_in,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] digit,
  output logic       borrow_out
);

  logic [3:0] r_digit;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)                  r_digit <= 4'd0;
    else if (load)             r_digit <= load_val;
    else if (dec && borrow_in) r_digit <= (r_digit == 4'd0) ? WRAP_VAL : r_digit - 4'd1;
  end

  assign digit      = r_digit;
  assign borrow_out = (r_digit == 4'd0) && borrow_in;

endmodule

// File: rtl/countdown_timer_bcd.sv
// countdown_timer_bcd
//   BCD countdown timer: digits keyed in at sec_ones, counted down once per
//   TICK_DIV clocks, with start, pause/resume, cancel and a done pulse.
//   Optional +30 s quick key when TIMER_QUICK_ADD_EN is defined.
// Ports
//   clk, clr (async active-low), load/data (digit entry), start, pause,
//   cancel, add30 (TIMER_QUICK_ADD_EN only); sec_ones, sec_tens,
//   mins (MSD in top nibble), zero, running, done (one-cycle pulse).
module countdown_timer_bcd
  import countdown_timer_bcd_pkg::*;
#(
  parameter int MIN_DIGITS = 2,
  parameter int TICK_DIV   = 50000000
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    load,
  input  logic [3:0]              data,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    cancel,
`ifdef TIMER_QUICK_ADD_EN
  input  logic                    add30,
`endif
  output logic [3:0]              sec_ones,
  output logic [3:0]              sec_tens,
  output logic [4*MIN_DIGITS-1:0] mins,
  output logic                    zero,
  output logic                    running,
  output logic                    done
);

  localparam int ND = MIN_DIGITS + 2;
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   L_WRAP    = PW'(TICK_DIV - 1);
  localparam logic [4*ND-1:0] L_ONE_SEC = {{(4*ND-1){1'b0}}, 1'b1};

  state_t               r_state, w_nxt_state;
  logic [PW-1:0]        r_presc;
  logic                 r_done;
  logic                 w_presc_clr, w_presc_inc, w_tick, w_done_nxt;
  logic [ND-1:0][3:0]   w_dig;
  logic [ND-1:0][3:0]   w_ld_val;
  logic [ND-1:0]        w_ld;
  logic [ND:0]          w_borrow;

  // digit 0 = sec_ones, 1 = sec_tens, 2.. = minutes
  assign w_borrow[0] = 1'b1;
  generate
    for (genvar i = 0; i < ND; i++) begin : g_dig
      bcd_down_digit #(
        .WRAP_VAL ((i == 1) ? SEC_TENS_MAX : BCD_MAX)
      ) u_dig (
        .clk        (clk),
        .clr        (clr),
        .dec        (w_tick),
        .borrow_in  (w_borrow[i]),
        .load       (w_ld[i]),
        .load_val   (w_ld_val[i]),
        .digit      (w_dig[i]),
        .borrow_out (w_borrow[i+1])
      );
    end
  endgenerate

`ifdef TIMER_QUICK_ADD_EN
  // +30 s: bump sec_tens by 3, fold back past 5 and ripple a BCD carry up
  // the minutes. A carry out of the top minute saturates at max time.
  logic [ND-1:0][3:0] w_add_val;
  logic [3:0]         w_t3;
  logic               w_c;
  always_comb begin
    w_add_val    = w_dig;
    w_t3         = w_dig[1] + 4'd3;
    w_c          = (w_t3 >= 4'd6);
    w_add_val[1] = w_c ? (w_t3 - 4'd6) : w_t3;
    for (int i = 2; i < ND; i++) begin
      if (w_c) begin
        if (w_dig[i] == BCD_MAX) w_add_val[i] = 4'd0;
        else begin
          w_add_val[i] = w_dig[i] + 4'd1;
          w_c          = 1'b0;
        end
      end
    end
    if (w_c) begin
      for (int i = 2; i < ND; i++) w_add_val[i] = BCD_MAX;
      w_add_val[1] = SEC_TENS_MAX;
      w_add_val[0] = BCD_MAX;
    end
  end
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= ST_IDLE;
      r_presc <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_done  <= w_done_nxt;
      if (w_presc_clr)      r_presc <= '0;
      else if (w_presc_inc) r_presc <= r_presc + 1'b1;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_presc_clr = 1'b0;
    w_presc_inc = 1'b0;
    w_tick      = 1'b0;
    w_done_nxt  = 1'b0;
    w_ld        = '0;
    w_ld_val    = '0;
    if (cancel) begin
      w_nxt_state = ST_IDLE;
      w_presc_clr = 1'b1;
      w_ld        = '1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && !zero) begin
            w_nxt_state = ST_RUN;
            w_presc_clr = 1'b1;
          end
`ifdef TIMER_QUICK_ADD_EN
          else if (add30 && zero) begin
            w_nxt_state = ST_RUN;
            w_presc_clr = 1'b1;
            w_ld        = '1;
            w_ld_val[1] = 4'd3;
          end
`endif
          else if (load && (data <= BCD_MAX)) begin
            w_ld     = '1;
            w_ld_val = {w_dig[ND-2:0], data};
          end
        end
        ST_RUN: begin
          if (pause) w_nxt_state = ST_PAUSED;
`ifdef TIMER_QUICK_ADD_EN
          // The add cycle holds the prescaler so no tick collides with the load.
          if (add30) begin
            w_ld     = '1;
            w_ld_val = w_add_val;
          end else
`endif
          if (!pause) begin
            if (r_presc == L_WRAP) begin
              w_tick      = 1'b1;
              w_presc_clr = 1'b1;
              // Only 00:01 can decrement to all-zero.
              if (w_dig == L_ONE_SEC) begin
                w_done_nxt  = 1'b1;
                w_nxt_state = ST_IDLE;
              end
            end else begin
              w_presc_inc = 1'b1;
            end
          end
        end
        ST_PAUSED: begin
          if (start) w_nxt_state = ST_RUN;
`ifdef TIMER_QUICK_ADD_EN
          if (add30) begin
            w_ld     = '1;
            w_ld_val = w_add_val;
          end
`endif
        end
        default: w_nxt_state = ST_IDLE;
      endcase
    end
  end

  // The borrow chain ANDs digit==0 across every digit: it is the zero flag.
  assign zero     = w_borrow[ND];
  assign sec_ones = w_dig[0];
  assign sec_tens = w_dig[1];
  assign mins     = w_dig[ND-1:2];
  assign running  = (r_state == ST_RUN);
  assign done     = r_done;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
module tb_countdown_timer_bcd;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        load = 1'b0, start = 1'b0, pause = 1'b0, cancel = 1'b0;
  logic [3:0]  data = 4'd0;
`ifdef TIMER_QUICK_ADD_EN
  logic        add30 = 1'b0;
`endif
  logic [3:0]  sec_ones, sec_tens;
  logic [7:0]  mins;
  logic        zero, running, done;
  int          n_chk = 0, n_err = 0;

  countdown_timer_bcd #(.MIN_DIGITS(2), .TICK_DIV(4)) dut (
    .clk      (clk),
    .clr      (clr),
    .load     (load),
    .data     (data),
    .start    (start),
    .pause    (pause),
    .cancel   (cancel),
`ifdef TIMER_QUICK_ADD_EN
    .add30    (add30),
`endif
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .mins     (mins),
    .zero     (zero),
    .running  (running),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] tval();
    return {mins, sec_tens, sec_ones};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    load = 1'b1; data = d;
    step();
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_cancel();
    cancel = 1'b1; step(); cancel = 1'b0;
  endtask

  initial begin
    // async reset with no clock edge
    #2 clr = 1'b0;
    #1;
    chk("rst_val",  32'(tval()), 32'h0000);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_run",  32'(running), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    step();
    clr = 1'b1;
    step();

    // keying and ignored loads
    key(4'd5); key(4'd4); key(4'd3);
    chk("key_543", 32'(tval()), 32'h0543);
    key(4'hA);
    chk("key_bad", 32'(tval()), 32'h0543);
    pulse_start();
    chk("start_run", 32'(running), 32'd1);
    key(4'd7);
    chk("key_run", 32'(tval()), 32'h0543);

    // clr mid-RUN, checked between edges
    #2 clr = 1'b0;
    #1;
    chk("clr_val",  32'(tval()), 32'h0000);
    chk("clr_zero", 32'(zero), 32'd1);
    chk("clr_run",  32'(running), 32'd0);
    chk("clr_done", 32'(done), 32'd0);
    step();
    clr = 1'b1;

    // start at zero is ignored
    pulse_start();
    chk("start_zero", 32'(running), 32'd0);

    // 01:00 -> 00:59
    key(4'd1); key(4'd0); key(4'd0);
    pulse_start();
    repeat (3) step();
    chk("pre_dec", 32'(tval()), 32'h0100);
    step();
    chk("borrow2", 32'(tval()), 32'h0059);
    pulse_cancel();

    // sec_tens above 5 counts down normally: 1:90 -> 1:89
    key(4'd1); key(4'd9); key(4'd0);
    pulse_start();
    repeat (4) step();
    chk("tens9", 32'(tval()), 32'h0189);
    pulse_cancel();
    chk("cancel_val", 32'(tval()), 32'h0000);
    chk("cancel_run", 32'(running), 32'd0);

    // 00:02 -> done at cycle 8
    key(4'd2);
    pulse_start();
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 4) chk("exp_mid", 32'(tval()), 32'h0001);
      chk($sformatf("done_c%0d", i), 32'(done), (i == 8) ? 32'd1 : 32'd0);
    end
    chk("exp_val", 32'(tval()), 32'h0000);
    chk("exp_run", 32'(running), 32'd0);
    step();
    chk("done_off", 32'(done), 32'd0);

    // pause at 00:30 with prescaler at 2, resume, then cancel
    key(4'd3); key(4'd1);
    pulse_start();
    repeat (4) step();
    chk("p_at30", 32'(tval()), 32'h0030);
    repeat (2) step();
    pause = 1'b1; step(); pause = 1'b0;
    repeat (20) step();
    chk("p_hold", 32'(tval()), 32'h0030);
    chk("p_run", 32'(running), 32'd0);
    pulse_start();
    chk("r_run", 32'(running), 32'd1);
    step();
    chk("r_wait", 32'(tval()), 32'h0030);
    step();
    chk("r_dec", 32'(tval()), 32'h0029);
    pulse_cancel();
    chk("c_val", 32'(tval()), 32'h0000);
    chk("c_done", 32'(done), 32'd0);
    step();
    chk("c_done2", 32'(done), 32'd0);

`ifdef TIMER_QUICK_ADD_EN
    add30 = 1'b1; step(); add30 = 1'b0;
    chk("a30_zero", 32'(tval()), 32'h0030);
    chk("a30_run", 32'(running), 32'd1);
    pulse_cancel();
    key(4'd4); key(4'd5);
    pulse_start();
    add30 = 1'b1; step(); add30 = 1'b0;
    chk("a30_45", 32'(tval()), 32'h0115);
    pulse_cancel();
    key(4'd9); key(4'd9); key(4'd5); key(4'd9);
    pulse_start();
    add30 = 1'b1; step(); add30 = 1'b0;
    chk("a30_sat", 32'(tval()), 32'h9959);
    pulse_cancel();
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
